// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART constants, receiver FSM state type and the
//             3-input majority helper used by the bit sampler.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Width of one UART character.
    localparam int c_BYTE = 8;

    // Clocks per bit shared by the transmitter and the receiver.
    localparam int c_BIT_PERIOD_DEFAULT = 290;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rxState_e;

    // Two-out-of-three vote across consecutive line samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_receiver_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : uart_receiver_if
//  Purpose  : Serial line input and received-byte outputs of the UART
//             receiver. master = receiver, slave = line driver / consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_receiver_if;
    import uart_pkg::*;

    logic              RxD;
    logic [c_BYTE-1:0] RxD_data;
    logic              data_ready;
    logic              frame_err;
    logic              busy;

    modport master (
        input  RxD,
        output RxD_data,
        output data_ready,
        output frame_err,
        output busy
    );

    modport slave (
        output RxD,
        input  RxD_data,
        input  data_ready,
        input  frame_err,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_bit_sampler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : uart_bit_sampler
//  Purpose  : Brings the asynchronous RxD line into the clock domain, flags
//             the 1->0 start edge and majority-votes three consecutive
//             samples around the middle of each bit period.
//  Revision : 1.0  initial release
// ============================================================================
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int HALF_PERIOD = 8,
    parameter int CNT_W       = 4
)
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_rxd,
    input  wire logic [CNT_W-1:0] i_bitCnt,
    output logic                  o_rxdS,
    output logic                  o_startEdge,
    output logic                  o_samplePoint,
    output logic                  o_bitVal
);

    localparam logic [CNT_W-1:0] c_SAMPLE0 = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_SAMPLE1 = CNT_W'(HALF_PERIOD);
    localparam logic [CNT_W-1:0] c_SAMPLE2 = CNT_W'(HALF_PERIOD + 1);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_s0;
    logic r_s1;

    // Synchroniser chain, edge-detect flop and the two early mid-bit samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (i_bitCnt == c_SAMPLE0) begin
                r_s0 <= r_sync2;
            end
            if (i_bitCnt == c_SAMPLE1) begin
                r_s1 <= r_sync2;
            end
        end
    end

    // The third sample is the live synchronised line, so the vote is
    // available in the same cycle the counter reaches the sample point.
    assign o_rxdS        = r_sync2;
    assign o_startEdge   = r_sync3 & ~r_sync2;
    assign o_samplePoint = (i_bitCnt == c_SAMPLE2);
    assign o_bitVal      = majority3(r_s0, r_s1, r_sync2);

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : 8N1/8N2 serial-to-byte receiver, LSB first, idle high.
//             Qualifies the start bit, majority-samples each bit at
//             mid-period and presents each good byte with a one-cycle
//             data_ready pulse; a low stop bit gives a frame_err pulse.
//  Revision : 1.0  initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BIT_PERIOD = c_BIT_PERIOD_DEFAULT
)
(
    input  wire logic      clk,
    input  wire logic      rst,
    uart_receiver_if.master bus
);

    localparam int               HALF_PERIOD = BIT_PERIOD / 2;
    localparam int               c_CNT_W     = $clog2(BIT_PERIOD);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BIT_PERIOD - 1);

    rxState_e           r_state;
    rxState_e           w_nextState;
    logic [c_CNT_W-1:0] r_bitCnt;
    logic [2:0]         r_idx;
    logic [c_BYTE-1:0]  r_shift;
    logic [c_BYTE-1:0]  r_data;
    logic               r_dataReady;
    logic               r_frameErr;
    logic               r_edgeFlag;

    logic w_rxdS;
    logic w_startEdge;
    logic w_samplePoint;
    logic w_bitVal;
    logic w_wrap;
    logic w_shiftEn;
    logic w_idxInc;
    logic w_load;
    logic w_ferr;

    uart_bit_sampler #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (c_CNT_W)
    ) u_sampler (
        .clk           (clk),
        .rst           (rst),
        .i_rxd         (bus.RxD),
        .i_bitCnt      (r_bitCnt),
        .o_rxdS        (w_rxdS),
        .o_startEdge   (w_startEdge),
        .o_samplePoint (w_samplePoint),
        .o_bitVal      (w_bitVal)
    );

    assign w_wrap = (r_bitCnt == c_CNT_MAX);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        w_nextState = r_state;
        w_shiftEn   = 1'b0;
        w_idxInc    = 1'b0;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                // A start edge that landed in the last STOP cycle is
                // recovered here if the line is still low.
                if (w_startEdge || (r_edgeFlag && !w_rxdS)) begin
                    w_nextState = START;
                end
            end
            START: begin
                if (w_samplePoint && w_bitVal) begin
                    w_nextState = IDLE;
                end else if (w_wrap) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_samplePoint) begin
                    w_shiftEn = 1'b1;
                end
                if (w_wrap) begin
                    if (r_idx == 3'd7) begin
                        w_nextState = STOP;
                    end else begin
                        w_idxInc = 1'b1;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a following frame with a
                // single stop bit can start on time.
                if (w_samplePoint) begin
                    if (w_bitVal) begin
                        w_load      = 1'b1;
                        w_nextState = IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_nextState = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (w_rxdS) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Bit-period counter: restarts on every state change and at each wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitCnt <= '0;
        end else if ((w_nextState != r_state) || (r_state == IDLE) || w_wrap) begin
            r_bitCnt <= '0;
        end else begin
            r_bitCnt <= r_bitCnt + c_CNT_W'(1);
        end
    end

    // Data bit index within the character.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= 3'd0;
        end else if ((r_state != DATA) && (w_nextState == DATA)) begin
            r_idx <= 3'd0;
        end else if (w_idxInc) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    // LSB-first shift register, output byte and the result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_data      <= '0;
            r_dataReady <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            if (w_shiftEn) begin
                r_shift <= {w_bitVal, r_shift[c_BYTE-1:1]};
            end
            if (w_load) begin
                r_data <= r_shift;
            end
            r_dataReady <= w_load;
            r_frameErr  <= w_ferr;
        end
    end

    // Remembers a start edge seen during STOP for the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edgeFlag <= 1'b0;
        end else begin
            r_edgeFlag <= (r_state == STOP) && w_startEdge;
        end
    end

    assign bus.RxD_data   = r_data;
    assign bus.data_ready = r_dataReady;
    assign bus.frame_err  = r_frameErr;
    assign bus.busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Self-checking bench for uart_receiver: a behavioural serial
//             line driver, byte queues as the reference model, directed
//             scenarios plus a randomized 256-byte loopback.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_receiver;

    localparam int P  = 16;
    localparam int P2 = 290;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_receiver_if ifA ();
    uart_receiver_if ifB ();

    uart_receiver #(.BIT_PERIOD(P)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    uart_receiver #(.BIT_PERIOD(P2)) u_dut290 (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int startCyc  = 0;
    int pulseCycA = 0;
    int ferrA = 0;
    int ferrB = 0;
    bit prevA = 1'b0;
    bit prevB = 1'b0;
    logic [7:0] rxQA [$];
    logic [7:0] rxQB [$];
    logic [7:0] lastByte = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Collects pulses from the fast receiver and checks pulse exclusivity.
    always @(negedge clk) begin
        if (ifA.data_ready || ifA.frame_err) begin
            checks++;
            if (ifA.data_ready && ifA.frame_err) begin
                errors++;
                $display("FAIL pulse_excl_A data_ready=1 frame_err=1 required not both");
            end
            if (prevA) begin
                errors++;
                $display("FAIL pulse_repeat_A pulse on consecutive cycles at cyc %0d", cyc);
            end
        end
        if (ifA.data_ready) begin
            rxQA.push_back(ifA.RxD_data);
            pulseCycA = cyc;
        end
        if (ifA.frame_err) ferrA++;
        prevA = ifA.data_ready | ifA.frame_err;
    end

    // Collects pulses from the BIT_PERIOD=290 receiver.
    always @(negedge clk) begin
        if (ifB.data_ready || ifB.frame_err) begin
            checks++;
            if (prevB || (ifB.data_ready && ifB.frame_err)) begin
                errors++;
                $display("FAIL pulse_rule_B dr=%0b fe=%0b prev=%0b", ifB.data_ready, ifB.frame_err, prevB);
            end
        end
        if (ifB.data_ready) rxQB.push_back(ifB.RxD_data);
        if (ifB.frame_err) ferrB++;
        prevB = ifB.data_ready | ifB.frame_err;
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) ifB.RxD = v;
        else     ifA.RxD = v;
    endtask

    // Behavioural transmitter: start, 8 data bits LSB first, nStop stop
    // periods at stopVal; optional 1-clock low glitch mid data bit glitchBit.
    task automatic sendFrame(input logic [7:0] b, input int nStop, input logic stopVal,
                             input int glitchBit, input bit sel);
        int p;
        p = sel ? P2 : P;
        drive(sel, 1'b0);
        startCyc = cyc;
        waitClk(p);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            if (i == glitchBit) begin
                waitClk(p / 2);
                drive(sel, 1'b0);
                waitClk(1);
                drive(sel, b[i]);
                waitClk(p - p / 2 - 1);
            end else begin
                waitClk(p);
            end
        end
        drive(sel, stopVal);
        waitClk(p * nStop);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifA.RxD = 1'b1;
        ifB.RxD = 1'b1;
        waitClk(5);
        checks++; if (ifA.RxD_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", ifA.RxD_data); end
        checks++; if (ifA.data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ifA.data_ready); end
        checks++; if (ifA.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", ifA.frame_err); end
        checks++; if (ifA.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ifA.busy); end
        checks++; if (ifB.busy !== 1'b0 || ifB.RxD_data !== 8'h00) begin errors++; $display("FAIL reset_B busy=%b data=%h exp 0/00", ifB.busy, ifB.RxD_data); end
        rst = 1'b0;
        waitClk(4);
        checks++; if (ifA.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", ifA.busy); end
    endtask

    task automatic test_single();
        int lat;
        int expLat;
        rxQA.delete(); ferrA = 0;
        sendFrame(8'hA5, 2, 1'b1, -1, 1'b0);
        waitClk(2 * P);
        expLat = 2 + 9 * P + P / 2 + 3;
        lat = pulseCycA - startCyc;
        checks++; if (rxQA.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", rxQA.size()); end
        else begin
            checks++; if (rxQA[0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp A5", rxQA[0]); end
            checks++; if (lat < expLat - 1 || lat > expLat + 1) begin errors++; $display("FAIL single_latency got %0d exp %0d+/-1", lat, expLat); end
        end
        checks++; if (ferrA != 0) begin errors++; $display("FAIL single_ferr got %0d exp 0", ferrA); end
        checks++; if (ifA.RxD_data !== 8'hA5) begin errors++; $display("FAIL single_hold got %h exp A5", ifA.RxD_data); end
        lastByte = 8'hA5;
    endtask

    task automatic test_back_to_back();
        rxQA.delete(); ferrA = 0;
        sendFrame(8'h00, 1, 1'b1, -1, 1'b0);
        sendFrame(8'hFF, 1, 1'b1, -1, 1'b0);
        waitClk(2 * P);
        checks++; if (rxQA.size() != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", rxQA.size()); end
        else begin
            checks++; if (rxQA[0] !== 8'h00 || rxQA[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data got %h %h exp 00 FF", rxQA[0], rxQA[1]); end
        end
        checks++; if (ferrA != 0) begin errors++; $display("FAIL b2b_ferr got %0d exp 0", ferrA); end
        lastByte = 8'hFF;
    endtask

    task automatic test_glitch_start();
        rxQA.delete(); ferrA = 0;
        drive(1'b0, 1'b0);
        waitClk(4);
        drive(1'b0, 1'b1);
        waitClk(2);
        checks++; if (ifA.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi got %b exp 1", ifA.busy); end
        waitClk(3 * P);
        checks++; if (ifA.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo got %b exp 0", ifA.busy); end
        checks++; if (rxQA.size() != 0 || ferrA != 0) begin errors++; $display("FAIL glitch_pulse got %0d bytes %0d ferr exp 0 0", rxQA.size(), ferrA); end
    endtask

    task automatic test_frame_err();
        rxQA.delete(); ferrA = 0;
        sendFrame(8'h3C, 3, 1'b0, -1, 1'b0);
        checks++; if (ferrA != 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", ferrA); end
        checks++; if (rxQA.size() != 0) begin errors++; $display("FAIL ferr_nobyte got %0d exp 0", rxQA.size()); end
        checks++; if (ifA.RxD_data !== lastByte) begin errors++; $display("FAIL ferr_hold got %h exp %h", ifA.RxD_data, lastByte); end
        checks++; if (ifA.busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_hi got busy %b exp 1", ifA.busy); end
        drive(1'b0, 1'b1);
        waitClk(P);
        checks++; if (ifA.busy !== 1'b0) begin errors++; $display("FAIL ferr_rearm got busy %b exp 0", ifA.busy); end
        sendFrame(8'h81, 1, 1'b1, -1, 1'b0);
        waitClk(2 * P);
        checks++; if (rxQA.size() != 1 || ifA.RxD_data !== 8'h81) begin errors++; $display("FAIL ferr_next got %0d bytes data %h exp 1 81", rxQA.size(), ifA.RxD_data); end
        lastByte = 8'h81;
    endtask

    task automatic test_glitch_data();
        rxQA.delete(); ferrA = 0;
        sendFrame(8'hFF, 1, 1'b1, 3, 1'b0);
        waitClk(2 * P);
        checks++; if (rxQA.size() != 1) begin errors++; $display("FAIL gdata_count got %0d exp 1", rxQA.size()); end
        else begin
            checks++; if (rxQA[0] !== 8'hFF) begin errors++; $display("FAIL gdata_value got %h exp FF", rxQA[0]); end
        end
        lastByte = 8'hFF;
    endtask

    task automatic test_reset_mid();
        rxQA.delete(); ferrA = 0;
        fork
            begin
                waitClk(5 * P);
                rst = 1'b1;
            end
            sendFrame(8'h55, 1, 1'b1, -1, 1'b0);
        join
        waitClk(2);
        checks++; if (ifA.RxD_data !== 8'h00 || ifA.busy !== 1'b0) begin errors++; $display("FAIL rstmid_state data=%h busy=%b exp 00 0", ifA.RxD_data, ifA.busy); end
        rst = 1'b0;
        lastByte = 8'h00;
        waitClk(P);
        checks++; if (rxQA.size() != 0 || ferrA != 0) begin errors++; $display("FAIL rstmid_nopulse got %0d bytes %0d ferr exp 0 0", rxQA.size(), ferrA); end
        sendFrame(8'h96, 1, 1'b1, -1, 1'b0);
        waitClk(2 * P);
        checks++; if (rxQA.size() != 1 || ifA.RxD_data !== 8'h96) begin errors++; $display("FAIL rstmid_next got %0d bytes data %h exp 1 96", rxQA.size(), ifA.RxD_data); end
        lastByte = 8'h96;
    endtask

    task automatic test_loopback();
        logic [7:0] expQ [$];
        logic [7:0] b;
        rxQA.delete(); ferrA = 0;
        for (int n = 0; n < 256; n++) begin
            b = 8'($urandom);
            expQ.push_back(b);
            sendFrame(b, int'($urandom_range(1, 2)), 1'b1, -1, 1'b0);
            waitClk(int'($urandom_range(0, 3)));
        end
        waitClk(2 * P);
        checks++; if (rxQA.size() != expQ.size()) begin errors++; $display("FAIL loop_count got %0d exp %0d", rxQA.size(), expQ.size()); end
        for (int n = 0; n < expQ.size() && n < rxQA.size(); n++) begin
            checks++;
            if (rxQA[n] !== expQ[n]) begin errors++; $display("FAIL loop_byte[%0d] got %h exp %h", n, rxQA[n], expQ[n]); end
        end
        checks++; if (ferrA != 0) begin errors++; $display("FAIL loop_ferr got %0d exp 0", ferrA); end
    endtask

    task automatic test_period290();
        logic [7:0] b0;
        logic [7:0] b1;
        rxQB.delete(); ferrB = 0;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        sendFrame(b0, 1, 1'b1, -1, 1'b1);
        sendFrame(b1, 2, 1'b1, -1, 1'b1);
        waitClk(P2);
        checks++; if (rxQB.size() != 2) begin errors++; $display("FAIL p290_count got %0d exp 2", rxQB.size()); end
        else begin
            checks++; if (rxQB[0] !== b0 || rxQB[1] !== b1) begin errors++; $display("FAIL p290_data got %h %h exp %h %h", rxQB[0], rxQB[1], b0, b1); end
        end
        checks++; if (ferrB != 0) begin errors++; $display("FAIL p290_ferr got %0d exp 0", ferrB); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch_start();
        test_frame_err();
        test_glitch_data();
        test_reset_mid();
        test_loopback();
        test_period290();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
